// File: rtl/sumador_arbiter.sv
// Round-robin arbiter/sequencer sharing one registered adder among N_REQ requesters.
// Define SUMADOR_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no grant pointer).
module sumador_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 4,
    parameter int ADD_LAT = 1,
    parameter int ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    output logic [WIDTH-1:0]       rsp_data,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   busy,
    output logic                   add_enb,
    output logic [WIDTH-1:0]       add_a,
    output logic [WIDTH-1:0]       add_b,
    input  logic [WIDTH-1:0]       add_c
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state, state_nxt;
    logic             found;
    logic [ID_W-1:0]  grant_id, lat_id;
    logic [N_REQ-1:0] grant_oh;
    logic [WIDTH-1:0] win_a, win_b, lat_a, lat_b;
    logic [1:0]       cnt;
`ifndef SUMADOR_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0]  last_grant;
`endif

    // Winner search uses only constant indices so every select stays width-clean.
    always_comb begin
        found    = 1'b0;
        grant_id = '0;
        grant_oh = '0;
        win_a    = '0;
        win_b    = '0;
`ifdef SUMADOR_ARB_FIXED_PRIO_EN
        for (int j = 0; j < N_REQ; j++) begin
            if (!found && req_valid[j]) begin
                found       = 1'b1;
                grant_id    = ID_W'(j);
                grant_oh[j] = 1'b1;
                win_a       = req_a[j*WIDTH +: WIDTH];
                win_b       = req_b[j*WIDTH +: WIDTH];
            end
        end
`else
        for (int k = 0; k < N_REQ; k++) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (!found && req_valid[j] && ((int'(last_grant) + 1 + k) % N_REQ) == j) begin
                    found       = 1'b1;
                    grant_id    = ID_W'(j);
                    grant_oh[j] = 1'b1;
                    win_a       = req_a[j*WIDTH +: WIDTH];
                    win_b       = req_b[j*WIDTH +: WIDTH];
                end
            end
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (cnt == 2'd0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lat_a    <= '0;
            lat_b    <= '0;
            lat_id   <= '0;
            cnt      <= '0;
            rsp_data <= '0;
            rsp_id   <= '0;
`ifndef SUMADOR_ARB_FIXED_PRIO_EN
            last_grant <= ID_W'(N_REQ - 1);
`endif
        end else begin
            state <= state_nxt;
            if (state == IDLE && found) begin
                lat_a  <= win_a;
                lat_b  <= win_b;
                lat_id <= grant_id;
            end
            if (state == ISSUE)
                cnt <= 2'(ADD_LAT - 1);
            else if (state == WAIT && cnt != 2'd0)
                cnt <= cnt - 2'd1;
            if (state == WAIT && cnt == 2'd0) begin
                rsp_data <= add_c;
                rsp_id   <= lat_id;
            end
`ifndef SUMADOR_ARB_FIXED_PRIO_EN
            if (state == RESP)
                last_grant <= rsp_id;
`endif
        end
    end

    // Ready is gated by reset so it reads zero while rst_n is low.
    assign req_ready = (rst_n && state == IDLE) ? grant_oh : '0;
    assign add_enb   = (state == ISSUE) || (state == WAIT);
    assign add_a     = add_enb ? lat_a : '0;
    assign add_b     = add_enb ? lat_b : '0;
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == RESP);

endmodule

// File: tb/tb_sumador_arbiter.sv
// Bench for sumador_arbiter: vector table plus a negedge monitor with a round-robin
// reference model and an expected-result queue; a behavioural registered adder is attached.
module tb_sumador_arbiter;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int AL = 1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a, req_b;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic [W-1:0]   rsp_data;
    logic [1:0]     rsp_id;
    logic           busy, add_enb;
    logic [W-1:0]   add_a, add_b;
    logic [W-1:0]   add_c = '0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    sumador_arbiter #(.N_REQ(N), .WIDTH(W), .ADD_LAT(AL), .ID_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .busy(busy), .add_enb(add_enb), .add_a(add_a), .add_b(add_b), .add_c(add_c)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (add_enb) add_c <= add_a + add_b;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int mwin(input logic [N-1:0] v, input int last);
        int j;
`ifdef SUMADOR_ARB_FIXED_PRIO_EN
        for (int k = 0; k < N; k++) if (v[k]) return k;
`else
        for (int k = 1; k <= N; k++) begin
            j = (last + k) % N;
            if (v[j[1:0]]) return j;
        end
`endif
        return -1;
    endfunction

    typedef struct { logic [1:0] id; logic [W-1:0] data; } exp_t;
    exp_t sb[$];
    int   mwait = 0;
    int   mlast = N - 1;

    // Reference model: tracks the transaction phase and the grant pointer independently.
    always @(negedge clk) begin
        exp_t e;
        int   w;
        if (!rst_n) begin
            chk("rst_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_data", rsp_data, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_busy", busy, 0);
            chk("rst_add", {add_enb, add_a, add_b}, 0);
            mwait = 0;
            mlast = N - 1;
            sb.delete();
        end else if (mwait > 0) begin
            chk("busy_ready", req_ready, 0);
            chk("busy_hi", busy, 1);
            if (mwait == 1) begin
                chk("resp_valid", rsp_valid, 1);
                chk("resp_enb", add_enb, 0);
                chk("sb_size", sb.size(), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("sb_id", rsp_id, e.id);
                    chk("sb_data", rsp_data, e.data);
                    mlast = e.id;
                end
            end else begin
                chk("wait_no_rsp", rsp_valid, 0);
                chk("wait_enb", add_enb, 1);
            end
            mwait--;
        end else begin
            chk("idle_busy", busy, 0);
            chk("idle_rsp", rsp_valid, 0);
            w = mwin(req_valid, mlast);
            chk("idle_ready", req_ready, (w < 0) ? 0 : (1 << w));
            if (w >= 0) begin
                e.id   = 2'(w);
                e.data = W'(req_a >> (W * w)) + W'(req_b >> (W * w));
                sb.push_back(e);
                mwait = AL + 2;
            end
        end
    end

    typedef struct {
        logic [N-1:0]   v;
        logic [N*W-1:0] a, b;
        logic [1:0]     id;
        logic [W-1:0]   data;
    } vec_t;
    vec_t vecs[7];

    task automatic wait_accept();
        bit got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (|(req_valid & req_ready)) got = 1;
        end
        chk("accept_seen", got, 1);
    endtask

    task automatic wait_rsp();
        bit got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) got = 1;
        end
        chk("rsp_seen", got, 1);
    endtask

    task automatic run_vec(input vec_t t);
        @(posedge clk); #1;
        req_valid = t.v; req_a = t.a; req_b = t.b;
        wait_accept();
        @(posedge clk); #1;
        req_valid = '0; req_a = '1; req_b = '1;
        wait_rsp();
        chk("vec_id", rsp_id, t.id);
        chk("vec_data", rsp_data, t.data);
        @(negedge clk);
        chk("hold_data", rsp_data, t.data);
    endtask

    initial begin
        int last_t;
        logic [1:0] seq_id;
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int t_prev;
        logic [1:0] exp_seq [5];
`ifdef SUMADOR_ARB_FIXED_PRIO_EN
        exp_seq = '{0, 0, 0, 0, 0};
`else
        exp_seq = '{0, 1, 2, 3, 0};
`endif
        vecs[0] = '{4'b0001, 16'h0000, 16'h0001, 2'd0, 4'd1};
        vecs[1] = '{4'b0100, 16'h0500, 16'h0200, 2'd2, 4'd7};
        vecs[2] = '{4'b0010, 16'h0090, 16'h0080, 2'd1, 4'd1};
        vecs[3] = '{4'b1000, 16'hF000, 16'hF000, 2'd3, 4'd14};
        vecs[4] = '{4'b0101, 16'h0603, 16'h0604, 2'd0, 4'd7};
`ifdef SUMADOR_ARB_FIXED_PRIO_EN
        vecs[5] = '{4'b0101, 16'h0603, 16'h0604, 2'd0, 4'd7};
        vecs[6] = '{4'b1010, 16'h1050, 16'h2050, 2'd1, 4'd10};
`else
        vecs[5] = '{4'b0101, 16'h0603, 16'h0604, 2'd2, 4'd12};
        vecs[6] = '{4'b1010, 16'h1050, 16'h2050, 2'd3, 4'd3};
`endif

        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // All requesters held: strict rotation, one result every ADD_LAT+3 cycles.
        @(posedge clk); #1;
        req_valid = 4'b1111; req_a = 16'h4321; req_b = 16'h1111;
        t_prev = 0;
        for (int i = 0; i < 5; i++) begin
            wait_rsp();
            chk("rr_id", rsp_id, exp_seq[i]);
            if (i > 0) chk("rr_spacing", cyc - t_prev, AL + 3);
            t_prev = cyc;
        end
        @(posedge clk); #1 req_valid = '0;

        // A request raised and dropped while busy is never served.
        @(posedge clk); #1;
        req_valid = 4'b0001; req_a = 16'h0001; req_b = 16'h0001;
        wait_accept();
        @(posedge clk); #1 req_valid = 4'b0100;
        @(posedge clk); #1 req_valid = '0;
        wait_rsp();
        chk("drop_id", rsp_id, 0);
        chk("drop_data", rsp_data, 2);
        repeat (8) @(posedge clk);

        // Reset during WAIT aborts the transaction and rewinds the pointer.
        @(posedge clk); #1;
        req_valid = 4'b1000; req_a = 16'h7000; req_b = 16'h7000;
        wait_accept();
        @(posedge clk); #1 req_valid = '0;
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        req_valid = 4'b1010; req_a = 16'h0020; req_b = 16'h0030;
        wait_rsp();
        chk("abort_id", rsp_id, 1);
        chk("abort_data", rsp_data, 5);
        @(posedge clk); #1 req_valid = '0;
        repeat (6) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
